// File: rtl/button_conditioner_if.sv
// Push-button conditioner bus: raw button level in, press pulse and debounced level out.
interface button_conditioner_if;
    logic btn_in;
    logic run;
    logic btn_level;

    modport master (output btn_in, input run, input btn_level);
    modport slave  (input btn_in, output run, output btn_level);
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes and debounces a push button, emitting a one-cycle run pulse per accepted press.
// Define BUTTON_CONDITIONER_AUTO_REPEAT_EN to add auto-repeat run pulses while the button is held.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_PERIOD   = 4
) (
    input  logic clk,
    input  logic reset,
    button_conditioner_if.slave bus
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
        REPEAT_DELAY < 2 || REPEAT_DELAY > 65535 ||
        REPEAT_PERIOD < 2 || REPEAT_PERIOD > 65535) begin : g_param_check
        $error("button_conditioner: parameter out of range 2..65535");
    end

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             sync1, sync2;
    logic             run_q, level_q;
    logic             run_press, run_rpt, run_d, level_d;

    // Two-flop synchronizer; only sync2 feeds the FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.btn_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            run_q   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_d;
            run_q   <= run_d;
            level_q <= level_d;
        end
    end

    // Outputs are computed from next_state so they rise on the HELD-entry edge
    always_comb begin
        next_state = IDLE;
        cnt_d      = '0;
        run_press  = 1'b0;
        case (state)
            IDLE: begin
                if (sync2) next_state = PRESS_CHK;
            end
            PRESS_CHK: begin
                if (!sync2) begin
                    next_state = IDLE;
                end else if (cnt == CNT_MAX) begin
                    next_state = HELD;
                    run_press  = 1'b1;
                end else begin
                    next_state = PRESS_CHK;
                    cnt_d      = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                next_state = sync2 ? HELD : RELEASE_CHK;
            end
            RELEASE_CHK: begin
                if (sync2) begin
                    next_state = HELD;
                end else if (cnt == CNT_MAX) begin
                    next_state = IDLE;
                end else begin
                    next_state = RELEASE_CHK;
                    cnt_d      = cnt + CNT_W'(1);
                end
            end
            default: next_state = IDLE;
        endcase
        level_d = (next_state == HELD) || (next_state == RELEASE_CHK);
    end

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam int unsigned RPT_W = 16;

    logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc, rpt_limit;
    logic             rep_q, rep_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_q <= '0;
            rep_q <= 1'b0;
        end else begin
            rpt_q <= rpt_d;
            rep_q <= rep_d;
        end
    end

    // rpt_q counts HELD cycles since the last pulse; rep_q selects delay vs period
    always_comb begin
        rpt_d     = rpt_q;
        rep_d     = rep_q;
        run_rpt   = 1'b0;
        rpt_inc   = rpt_q + RPT_W'(1);
        rpt_limit = rep_q ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);
        if (next_state == HELD) begin
            if (state == PRESS_CHK) begin
                rpt_d = '0;
                rep_d = 1'b0;
            end else if (rpt_inc == rpt_limit) begin
                run_rpt = 1'b1;
                rpt_d   = '0;
                rep_d   = 1'b1;
            end else begin
                rpt_d = rpt_inc;
            end
        end else if (next_state == IDLE) begin
            rpt_d = '0;
            rep_d = 1'b0;
        end
    end
`else
    assign run_rpt = 1'b0;
`endif

    assign run_d         = run_press | run_rpt;
    assign bus.run       = run_q;
    assign bus.btn_level = level_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4, REPEAT 8/4).
module tb_button_conditioner;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam bit AUTO_REP = 1'b1;
`else
    localparam bit AUTO_REP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   pulses   = 0;
    int   p0;

    always #5 clk = ~clk;

    button_conditioner_if bus();

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.run === 1'b1) pulses++;
    endtask

    // Drive btn for n edges; tick t (1-based) samples just after edge E(t-1).
    // run expected at tick run_at (plus repeat indices if rep), level flips at tick lvl_at.
    task automatic phase(input string tag, input logic btn, input int n, input int run_at,
                         input int lvl_at, input logic lvl_before, input bit rep);
        bus.btn_in = btn;
        for (int t = 1; t <= n; t++) begin
            logic exp_run;
            logic exp_lvl;
            int   idx;
            tick();
            idx     = t - run_at;
            exp_run = (t == run_at) ||
                      (rep && AUTO_REP && idx >= 8 && ((idx - 8) % 4) == 0);
            exp_lvl = (t >= lvl_at) ? ~lvl_before : lvl_before;
            check($sformatf("%s.run@%0d", tag, t), bus.run, exp_run);
            check($sformatf("%s.level@%0d", tag, t), bus.btn_level, exp_lvl);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        bus.btn_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.run", bus.run, 1'b0);
        check("reset.level", bus.btn_level, 1'b0);
        reset = 1'b0;
        phase("idle", 1'b0, 3, 0, 4, 1'b0, 1'b0);

        // Clean long press: pulse and level after E6, then release
        phase("press", 1'b1, 20, 7, 7, 1'b0, 1'b1);
        phase("release", 1'b0, 10, 0, 7, 1'b1, 1'b0);

        // Short glitch never accepted
        phase("short_hi", 1'b1, 3, 0, 4, 1'b0, 1'b0);
        phase("short_lo", 1'b0, 10, 0, 11, 1'b0, 1'b0);

        // Release bounce: level holds, falls 6 edges after the final fall
        phase("hold", 1'b1, 10, 7, 7, 1'b0, 1'b1);
        phase("bounce_lo", 1'b0, 2, 0, 3, 1'b1, 1'b0);
        phase("bounce_hi", 1'b1, 1, 0, 2, 1'b1, 1'b0);
        phase("final_lo", 1'b0, 10, 0, 7, 1'b1, 1'b0);

        // Reset during PRESS_CHK with button held
        phase("pc", 1'b1, 3, 0, 4, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("rst_pc.run", bus.run, 1'b0);
        check("rst_pc.level", bus.btn_level, 1'b0);
        tick();
        tick();
        check("rst_pc_hold.level", bus.btn_level, 1'b0);
        reset = 1'b0;
        phase("post_rst", 1'b1, 10, 7, 7, 1'b0, 1'b1);

        // Asynchronous reset while HELD clears level without a clock edge
        reset = 1'b1;
        #1;
        check("rst_held.level", bus.btn_level, 1'b0);
        check("rst_held.run", bus.run, 1'b0);
        bus.btn_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        phase("post_rst_idle", 1'b0, 3, 0, 4, 1'b0, 1'b0);

        // Two clean presses: exactly two one-cycle pulses
        p0 = pulses;
        phase("a_hi", 1'b1, 10, 7, 7, 1'b0, 1'b1);
        phase("a_lo", 1'b0, 10, 0, 7, 1'b1, 1'b0);
        phase("b_hi", 1'b1, 10, 7, 7, 1'b0, 1'b1);
        phase("b_lo", 1'b0, 10, 0, 7, 1'b1, 1'b0);
        check_int("two_press.pulses", pulses - p0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive stable synchronized samples required to accept a level change; legal range 2..65535.
REQ-002 Parameter REPEAT_DELAY, default 8: HELD cycles before the first auto-repeat pulse; legal range 2..65535; used only with the REQ-021 macro defined.
REQ-003 Parameter REPEAT_PERIOD, default 4: HELD cycles between auto-repeat pulses; legal range 2..65535; used only with the REQ-021 macro defined.
REQ-004 Clock is clk, input, 1 bit: all state changes on its rising edge.
REQ-005 Reset is reset, input, 1 bit: asynchronous, active-high.
REQ-006 btn_in, input, 1 bit: raw, bouncing, clk-asynchronous push-button level; 1 = pressed.
REQ-007 run, output, 1 bit: registered single-cycle press pulse for the downstream sequencing FSM.
REQ-008 btn_level, output, 1 bit: registered debounced button level.

Function
REQ-009 btn_in SHALL pass through a 2-flop synchronizer; only its second-flop output (s) SHALL be used by the logic below.
REQ-010 FSM states SHALL be IDLE, PRESS_CHK, HELD and RELEASE_CHK, with a debounce counter cnt sized to hold DEBOUNCE_CYCLES-1.
REQ-011 IDLE transition: s=1 -> PRESS_CHK with cnt=0; otherwise stay in IDLE.
REQ-012 PRESS_CHK, s=0: return to IDLE and clear cnt.
REQ-013 PRESS_CHK, s=1: if cnt==DEBOUNCE_CYCLES-1, go to HELD; otherwise increment cnt.
REQ-014 HELD transition: s=0 -> RELEASE_CHK with cnt=0; otherwise stay in HELD.
REQ-015 RELEASE_CHK, s=1: return to HELD and clear cnt.
REQ-016 RELEASE_CHK, s=0: if cnt==DEBOUNCE_CYCLES-1, go to IDLE; otherwise increment cnt.
REQ-017 run SHALL be 1 for exactly one cycle, the first cycle in HELD after a PRESS_CHK->HELD transition; a RELEASE_CHK->HELD return SHALL NOT pulse run.
REQ-018 btn_level SHALL be 1 in HELD and RELEASE_CHK, and 0 in IDLE and PRESS_CHK.
REQ-019 Latency: with btn_in first sampled high at edge E0 and stable thereafter, run and btn_level SHALL rise after edge E(DEBOUNCE_CYCLES+2); release latency to btn_level fall SHALL be identical.
REQ-020 Unreachable state encodings SHALL return to IDLE on the next edge with run=0.

Configuration
REQ-021 With BUTTON_CONDITIONER_AUTO_REPEAT_EN defined, a repeat counter SHALL reset on HELD entry from PRESS_CHK, counting HELD cycles from index 0, where the REQ-017 pulse is index 0.
REQ-022 With the macro defined, run SHALL additionally pulse at indices REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD, REPEAT_DELAY+2*REPEAT_PERIOD, and so on.
REQ-023 With the macro defined, the repeat counter SHALL freeze in RELEASE_CHK and resume on a return to HELD; entering IDLE or asserting reset SHALL clear it.
REQ-024 Without the macro, the repeat counter and the REPEAT_* logic SHALL be absent, and exactly one run pulse SHALL occur per accepted press.

Reset
REQ-025 reset SHALL force state=IDLE, cnt=0, synchronizer flops=0, repeat counter=0, run=0 and btn_level=0 immediately, regardless of clk.
REQ-026 Reset asserted mid-operation, in any state, SHALL abort it; a press held across reset release SHALL see the full REQ-019 latency again.

Verification
REQ-027 DEBOUNCE_CYCLES=4, btn_in high from E0 for 20 cycles -> single run pulse and btn_level rise after E6; no further pulses with the macro undefined.
REQ-028 btn_in high for 3 cycles then low -> run and btn_level stay 0 throughout.
REQ-029 Held press, then btn_in low 2 cycles, high 1 cycle, then low stable -> btn_level falls 6 edges after the final fall is sampled; no run pulse at any point.
REQ-030 reset pulsed while in PRESS_CHK with btn_in held high -> outputs 0 at once; run rises 6 edges after the first post-reset edge.
REQ-031 Macro defined, REPEAT_DELAY=8, REPEAT_PERIOD=4, 30-cycle hold -> run pulses at HELD indices 0, 8, 12, 16, 20, 24; no pulse after release.
REQ-032 Two clean 10-cycle presses separated by 10 low cycles -> exactly two run pulses, each one cycle wide.
